// File: rtl/router_pkg.sv
// Shared router constants and byte helpers used by the register block, controller and FIFOs.
package router_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef logic [DATA_W-1:0] byte_t;

    function automatic logic addr_ok(input byte_t b);
        return b[ADDR_W-1:0] != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity of a packet, received parity capture and registered mismatch flag.
module router_parity_acc
    import router_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_clear,
    input  logic  i_acc_hdr,
    input  byte_t i_hdr_byte,
    input  logic  i_acc_data,
    input  byte_t i_data_byte,
    input  logic  i_cap_parity,
    input  byte_t i_parity_byte,
    input  logic  i_compare,
    output logic  o_err
);

    byte_t w_hdr_term;
    byte_t w_data_term;
    byte_t r_internal;
    byte_t r_packet;
    logic  r_err;

    assign w_hdr_term  = i_acc_hdr  ? i_hdr_byte  : '0;
    assign w_data_term = i_acc_data ? i_data_byte : '0;

    // Header and data terms are independent so overlapping strobes both contribute.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_internal <= '0;
            r_packet   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (i_clear)
                r_internal <= '0;
            else
                r_internal <= r_internal ^ w_hdr_term ^ w_data_term;

            if (i_cap_parity)
                r_packet <= i_parity_byte;

            if (i_clear)
                r_err <= 1'b0;
            else if (i_compare)
                r_err <= (r_internal != r_packet);
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/router_reg.sv
// Router register block: header/hold byte steering to the FIFO, parity-done and low-valid tracking.
module router_reg
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err
);

    byte_t r_header;
    byte_t r_hold;
    byte_t r_dout;
    logic  r_parity_done;
    logic  r_low_pkt_valid;

    logic  w_hdr_cap;
    logic  w_acc_data;
    logic  w_cap_parity;
    logic  w_done_set;

    assign w_hdr_cap    = detect_add && pkt_valid && addr_ok(data_in);
    assign w_acc_data   = ld_state && pkt_valid && !full_state;
    assign w_cap_parity = ld_state && !pkt_valid;
    assign w_done_set   = (ld_state && !fifo_full && !pkt_valid) ||
                          (laf_state && r_low_pkt_valid && !r_parity_done);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_header <= '0;
            r_hold   <= '0;
            r_dout   <= '0;
        end else begin
            if (w_hdr_cap)
                r_header <= data_in;

            // A byte offered while the FIFO is full is parked and replayed in laf_state.
            if (ld_state && fifo_full)
                r_hold <= data_in;

            if (lfd_state)
                r_dout <= r_header;
            else if (ld_state && !fifo_full)
                r_dout <= data_in;
            else if (laf_state)
                r_dout <= r_hold;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity_done   <= 1'b0;
            r_low_pkt_valid <= 1'b0;
        end else begin
            if (detect_add)
                r_parity_done <= 1'b0;
            else if (w_done_set)
                r_parity_done <= 1'b1;

            if (rst_int_reg)
                r_low_pkt_valid <= 1'b0;
            else if (w_cap_parity)
                r_low_pkt_valid <= 1'b1;
        end
    end

    router_parity_acc u_parity (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_clear       (detect_add),
        .i_acc_hdr     (lfd_state),
        .i_hdr_byte    (r_header),
        .i_acc_data    (w_acc_data),
        .i_data_byte   (data_in),
        .i_cap_parity  (w_cap_parity),
        .i_parity_byte (data_in),
        .i_compare     (r_parity_done),
        .o_err         (err)
    );

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: pkt_valid  in  1  source byte-valid; deasserts on the parity byte.
REQ-004 SHALL have port: data_in  in  8  packet byte: header {len[7:2], addr[1:0]}, payload, then parity.
REQ-005 SHALL have port: fifo_full  in  1  selected destination FIFO is full.
REQ-006 SHALL have ports: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  controller state strobes.
REQ-007 SHALL have port: dout  out  8  byte to the destination FIFO.
REQ-008 SHALL have port: parity_done  out  1  parity byte captured for the current packet.
REQ-009 SHALL have port: low_pkt_valid  out  1  pkt_valid fell while the controller was in load-data.
REQ-010 SHALL have port: err  out  1  computed parity differs from received parity.

Function
REQ-011 Header capture SHALL occur when detect_add && pkt_valid && data_in[1:0] != 2'b11: header_byte <= data_in; an address of 2'b11 SHALL be ignored.
REQ-012 dout SHALL update as follows, in priority order: lfd_state: dout <= header_byte; ld_state && !fifo_full: dout <= data_in; laf_state: dout <= hold_byte; otherwise dout holds.
REQ-013 When ld_state && fifo_full, data_in SHALL be latched into hold_byte and dout SHALL be unchanged; no byte SHALL be lost across a full stall.
REQ-014 internal_parity SHALL clear on detect_add.
REQ-015 On lfd_state, internal_parity SHALL XOR with header_byte.
REQ-016 On ld_state && pkt_valid && !full_state, internal_parity SHALL XOR with data_in; the parity byte itself SHALL NOT be accumulated.
REQ-017 On ld_state && !pkt_valid, packet_parity SHALL latch data_in.
REQ-018 parity_done SHALL set on the edge where ld_state && !fifo_full && !pkt_valid.
REQ-019 parity_done SHALL also set on the edge where laf_state && low_pkt_valid && !parity_done.
REQ-020 parity_done SHALL clear on detect_add and otherwise hold.
REQ-021 low_pkt_valid SHALL set on ld_state && !pkt_valid, clear on rst_int_reg, and otherwise hold; if both occur in the same cycle, clear SHALL win.
REQ-022 err SHALL be registered while parity_done==1 as (internal_parity != packet_parity), valid one cycle after parity_done rises, held until detect_add clears it to 0.
REQ-023 All arithmetic SHALL be 8-bit XOR with no width extension; byte count SHALL NOT be checked against len.
REQ-024 Simultaneous strobes SHALL NOT occur by controller contract; if they do, the REQ-012 priority SHALL govern dout and all other registers SHALL update independently.

Reset
REQ-025 While reset==1, dout, header_byte, hold_byte, internal_parity and packet_parity SHALL be 8'h00 and parity_done, low_pkt_valid and err SHALL be 0, asynchronously, regardless of clock.
REQ-026 Reset asserted mid-packet SHALL discard the packet.
REQ-027 After reset release, the first valid update SHALL be a header capture.

Structure
REQ-028 Shared package router_pkg SHALL hold DATA_W=8, ADDR_W=2 and ADDR_INVALID=2'b11, shared with the controller and FIFOs.
REQ-029 One sub-module, router_parity_acc (clear/accumulate/compare, 8-bit), SHALL be instantiated; byte steering SHALL stay in router_reg.

Verification
REQ-030 Normal packet: header 0x0D, payload 0x11,0x22,0x33, parity 0x0D -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1; err=0.
REQ-031 Corrupt parity: same packet with parity 0x0C -> err=1 one cycle after parity_done, cleared by the next detect_add.
REQ-032 Full stall: fifo_full asserted during ld_state with data_in=0x22 -> dout holds 0x11; on laf_state dout=0x22; parity unchanged and err=0.
REQ-033 Invalid address: detect_add && pkt_valid with data_in=0x0F -> header_byte unchanged (0x00 after reset).
REQ-034 Reset mid-payload after 0x11 -> all outputs 0 within the same cycle, without a clock edge; next packet 0x0D... checks clean with err=0.
REQ-035 low_pkt_valid: pkt_valid drops during ld_state -> low_pkt_valid=1 next cycle; rst_int_reg pulse -> 0.
